fifo_drain_2mhz: RTL and testbench
==================================

FIFO_DRAIN_2MHZ -- requirements
Module: fifo_drain_2mhz

Interface
REQ-001 Parameter BYTES_PER_PKT, default 4, number of FIFO bytes summed per RAM write; legal range 2..16.
REQ-002 Parameter ADDR_W, default 11, width of RAM address.
REQ-003 Derived constant SUM_W = 8 + clog2(BYTES_PER_PKT), 10 at default.
REQ-004 clk_2  input  1  2 MHz read-side clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 empty  input  1  FIFO empty flag, read-clock domain.
REQ-007 rd_data  input  8  FIFO read data, valid the cycle after rd is high.
REQ-008 rd  output  1  FIFO read strobe, one cycle per byte.
REQ-009 ram_wr  output  1  RAM write strobe, one cycle per packet.
REQ-010 ram_addr  output  ADDR_W  RAM write address.
REQ-011 ram_data  output  SUM_W  packet byte sum, valid while ram_wr high.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 addr_full  output  1  saturation flag (RAM_ADDR_SAT_EN only, else tied 0).

Function
REQ-014 FSM states IDLE, FETCH, CAPTURE, STORE; all outputs are registered or pure decodes of state/registers (no input-to-output combinational path).
REQ-015 IDLE: if empty==0 sampled at the edge, next state FETCH; else stay IDLE.
REQ-016 FETCH: rd=1 for exactly this cycle; next state CAPTURE unconditionally.
REQ-017 CAPTURE: sum <= sum + rd_data (zero-extended to SUM_W), byte_cnt <= byte_cnt + 1; next STORE if byte_cnt==BYTES_PER_PKT-1, else IDLE.
REQ-018 STORE: ram_wr=1 for exactly this cycle, ram_data=sum, ram_addr=current address; next IDLE with sum<=0, byte_cnt<=0, address<=address+1.
REQ-019 rd shall never be high unless empty was sampled 0 in the immediately preceding IDLE cycle; minimum byte spacing is 3 cycles.
REQ-020 empty is ignored in FETCH, CAPTURE and STORE.
REQ-021 Sum cannot overflow: max sum 255*BYTES_PER_PKT fits SUM_W.
REQ-022 ram_data shall equal the sum register at all times; consumers use it only when ram_wr=1.
REQ-023 rd and ram_wr are never high in the same cycle.
REQ-024 Address wrap without RAM_ADDR_SAT_EN: 2^ADDR_W-1 increments to 0.
REQ-025 Partial packets persist: byte_cnt and sum hold across any number of IDLE cycles while empty==1.

Reset
REQ-026 On reset high, immediately: state=IDLE, rd=0, ram_wr=0, ram_addr=0, sum=0, byte_cnt=0, busy=0, addr_full=0.
REQ-027 Reset asserted mid-packet discards the partial sum; the byte whose rd already issued is not captured.
REQ-028 First FETCH after reset release occurs no earlier than the second rising edge after release.

Configuration
REQ-029 Macro RAM_ADDR_SAT_EN: when defined, the STORE at address 2^ADDR_W-1 writes normally, then address holds, addr_full<=1 and stays 1 until reset; while addr_full=1, STORE suppresses ram_wr (FIFO still drained, sums discarded).
REQ-030 Without RAM_ADDR_SAT_EN: address wraps per REQ-024, addr_full constant 0, ram_wr never suppressed.

Verification
REQ-031 Reset, empty=0, FIFO bytes 0x01,0x02,0x03,0x04 -> four rd pulses 3 cycles apart, then ram_wr=1 with ram_addr=0, ram_data=10.
REQ-032 Bytes 0xFF x4 -> ram_data=1020 (0x3FC), no overflow; next packet writes ram_addr=1.
REQ-033 empty=1 after byte 2 for 20 cycles, then bytes 3,4 (0x10,0x20,0x30,0x40) -> no rd while empty, single ram_wr with ram_data=160.
REQ-034 Reset pulsed in CAPTURE of byte 3 -> all outputs 0 immediately; next packet 1,1,1,1 writes ram_data=4 at ram_addr=0.
REQ-035 ADDR_W=2, 5 packets of 0x01 x4: without macro ram_wr at addresses 0,1,2,3,0; with RAM_ADDR_SAT_EN writes at 0..3 only, addr_full=1 after 4th, fifth packet still issues 4 rd pulses, no ram_wr.
REQ-036 Throughout all tests: assertion that rd and ram_wr never coincide and rd never follows an IDLE cycle with empty=1.

Source files
------------

// File: rtl/fifo_drain_2mhz.sv
// Drains a byte FIFO on the 2 MHz read clock, summing BYTES_PER_PKT bytes per RAM write.
// Optional macro RAM_ADDR_SAT_EN: saturate the RAM address instead of wrapping.
module fifo_drain_2mhz #(
    parameter int BYTES_PER_PKT = 4,
    parameter int ADDR_W        = 11,
    localparam int SUM_W        = 8 + $clog2(BYTES_PER_PKT)
) (
    input  logic              clk_2,
    input  logic              reset,
    input  logic              empty,
    input  logic [7:0]        rd_data,
    output logic              rd,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [SUM_W-1:0]  ram_data,
    output logic              busy,
    output logic              addr_full
);

    localparam int CNT_W = $clog2(BYTES_PER_PKT);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] FETCH   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] STORE   = 2'd3;

    logic [1:0]        state;
    logic              armed;
    logic [SUM_W-1:0]  sum;
    logic [CNT_W-1:0]  byte_cnt;
    logic [ADDR_W-1:0] addr;
`ifdef RAM_ADDR_SAT_EN
    logic              full;
`endif

    // armed holds off the first FETCH until the second edge after reset release
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            armed    <= 1'b0;
            sum      <= '0;
            byte_cnt <= '0;
            addr     <= '0;
`ifdef RAM_ADDR_SAT_EN
            full     <= 1'b0;
`endif
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (armed && !empty)
                        state <= FETCH;
                end
                FETCH: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    sum      <= sum + SUM_W'(rd_data);
                    byte_cnt <= byte_cnt + CNT_W'(1);
                    if (byte_cnt == CNT_W'(BYTES_PER_PKT - 1))
                        state <= STORE;
                    else
                        state <= IDLE;
                end
                STORE: begin
                    sum      <= '0;
                    byte_cnt <= '0;
                    state    <= IDLE;
`ifdef RAM_ADDR_SAT_EN
                    if (!full) begin
                        if (addr == '1)
                            full <= 1'b1;
                        else
                            addr <= addr + ADDR_W'(1);
                    end
`else
                    addr <= addr + ADDR_W'(1);
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign rd       = (state == FETCH);
    assign ram_addr = addr;
    assign ram_data = sum;
    assign busy     = (state != IDLE);

`ifdef RAM_ADDR_SAT_EN
    // once saturated, packets are still drained but their sums are dropped
    assign ram_wr    = (state == STORE) && !full;
    assign addr_full = full;
`else
    assign ram_wr    = (state == STORE);
    assign addr_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_drain_2mhz.sv
// Scoreboard bench for fifo_drain_2mhz: default instance plus an ADDR_W=2 wrap/saturation instance.
`timescale 1ns/1ps
module tb_fifo_drain_2mhz;

    logic clk_2 = 1'b0;
    always #250 clk_2 = ~clk_2;

    logic        reset_a, empty_a, rd_a, ram_wr_a, busy_a, addr_full_a;
    logic [7:0]  rd_data_a;
    logic [10:0] ram_addr_a;
    logic [9:0]  ram_data_a;

    logic        reset_b, empty_b, rd_b, ram_wr_b, busy_b, addr_full_b;
    logic [7:0]  rd_data_b;
    logic [1:0]  ram_addr_b;
    logic [9:0]  ram_data_b;

    fifo_drain_2mhz #(.BYTES_PER_PKT(4), .ADDR_W(11)) dut_a (
        .clk_2(clk_2), .reset(reset_a), .empty(empty_a), .rd_data(rd_data_a),
        .rd(rd_a), .ram_wr(ram_wr_a), .ram_addr(ram_addr_a), .ram_data(ram_data_a),
        .busy(busy_a), .addr_full(addr_full_a)
    );

    fifo_drain_2mhz #(.BYTES_PER_PKT(4), .ADDR_W(2)) dut_b (
        .clk_2(clk_2), .reset(reset_b), .empty(empty_b), .rd_data(rd_data_b),
        .rd(rd_b), .ram_wr(ram_wr_b), .ram_addr(ram_addr_b), .ram_data(ram_data_b),
        .busy(busy_b), .addr_full(addr_full_b)
    );

    typedef struct {
        logic [10:0] addr;
        logic [9:0]  data;
    } exp_t;

    logic [7:0] q_a[$], q_b[$];
    exp_t       exp_a[$], exp_b[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         rd_cnt_a = 0;
    int         rd_cnt_b = 0;
    int         rd_times_a[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic pkt_a(input logic [7:0] b0, b1, b2, b3, input logic [10:0] addr, input logic [9:0] data);
        q_a.push_back(b0); q_a.push_back(b1); q_a.push_back(b2); q_a.push_back(b3);
        exp_a.push_back('{addr: addr, data: data});
    endtask

    task automatic drain(input bit sel_b, input int budget);
        int i = 0;
        if (!sel_b) begin
            while ((q_a.size() != 0 || busy_a || exp_a.size() != 0) && i < budget) begin
                @(posedge clk_2); #1; i++;
            end
        end else begin
            while ((q_b.size() != 0 || busy_b || exp_b.size() != 0) && i < budget) begin
                @(posedge clk_2); #1; i++;
            end
        end
        if (i >= budget) begin
            n_vec++; n_err++;
            $display("FAIL drain_timeout_%s: still busy after %0d cycles, required idle", sel_b ? "b" : "a", budget);
        end
        repeat (2) @(posedge clk_2);
        #1;
    endtask

    always @(posedge clk_2) cyc++;

    // FIFO models: pop a byte at the edge that ends the rd cycle, data valid next cycle
    initial begin : drv_a
        logic pend;
        empty_a = 1'b1; rd_data_a = '0;
        forever begin
            @(negedge clk_2); pend = rd_a;
            @(posedge clk_2); #1;
            if (pend && q_a.size() > 0) rd_data_a = q_a.pop_front();
            empty_a = (q_a.size() == 0);
        end
    end

    initial begin : drv_b
        logic pend;
        empty_b = 1'b1; rd_data_b = '0;
        forever begin
            @(negedge clk_2); pend = rd_b;
            @(posedge clk_2); #1;
            if (pend && q_b.size() > 0) rd_data_b = q_b.pop_front();
            empty_b = (q_b.size() == 0);
        end
    end

    initial begin : mon_a
        logic prev_ie;
        exp_t e;
        prev_ie = 1'b0;
        forever begin
            @(negedge clk_2);
            if (rd_a) begin rd_cnt_a++; rd_times_a.push_back(cyc); end
            if (rd_a || ram_wr_a) check("a_rd_wr_overlap", {31'd0, rd_a & ram_wr_a}, 32'd0);
            if (prev_ie) check("a_rd_after_empty", {31'd0, rd_a}, 32'd0);
            prev_ie = !busy_a && empty_a && !reset_a;
            if (ram_wr_a) begin
                if (exp_a.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL a_unexpected_wr: addr %0d data %0d, expected no write", ram_addr_a, ram_data_a);
                end else begin
                    e = exp_a.pop_front();
                    check("a_ram_addr", {21'd0, ram_addr_a}, {21'd0, e.addr});
                    check("a_ram_data", {22'd0, ram_data_a}, {22'd0, e.data});
                end
            end
        end
    end

    initial begin : mon_b
        logic prev_ie;
        exp_t e;
        prev_ie = 1'b0;
        forever begin
            @(negedge clk_2);
            if (rd_b) rd_cnt_b++;
            if (rd_b || ram_wr_b) check("b_rd_wr_overlap", {31'd0, rd_b & ram_wr_b}, 32'd0);
            if (prev_ie) check("b_rd_after_empty", {31'd0, rd_b}, 32'd0);
            prev_ie = !busy_b && empty_b && !reset_b;
            if (ram_wr_b) begin
                if (exp_b.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL b_unexpected_wr: addr %0d data %0d, expected no write", ram_addr_b, ram_data_b);
                end else begin
                    e = exp_b.pop_front();
                    check("b_ram_addr", {30'd0, ram_addr_b}, {21'd0, e.addr});
                    check("b_ram_data", {22'd0, ram_data_b}, {22'd0, e.data});
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        reset_a = 1'b1;
        reset_b = 1'b1;
        repeat (2) @(posedge clk_2);
        #1;
        check("a_reset_outputs", {26'd0, rd_a, ram_wr_a, busy_a, addr_full_a, 2'b00}, 32'd0);
        check("a_reset_addr", {21'd0, ram_addr_a}, 32'd0);
        check("a_reset_data", {22'd0, ram_data_a}, 32'd0);

        // bytes 1..4 with empty low before release
        pkt_a(8'h01, 8'h02, 8'h03, 8'h04, 11'd0, 10'd10);
        @(posedge clk_2); #1;
        rd_times_a.delete();
        reset_a = 1'b0;
        @(posedge clk_2);
        @(negedge clk_2);
        check("a_no_fetch_first_edge", {31'd0, rd_a}, 32'd0);
        drain(1'b0, 200);
        check("a_rd_pulses_pkt1", rd_times_a.size(), 32'd4);
        if (rd_times_a.size() == 4)
            for (int i = 0; i < 3; i++)
                check("a_rd_spacing", rd_times_a[i+1] - rd_times_a[i], 32'd3);

        // maximum sum, then the following address
        pkt_a(8'hFF, 8'hFF, 8'hFF, 8'hFF, 11'd1, 10'd1020);
        pkt_a(8'h01, 8'h01, 8'h01, 8'h01, 11'd2, 10'd4);
        drain(1'b0, 200);

        // partial packet held across 20 empty cycles
        q_a.push_back(8'h10); q_a.push_back(8'h20);
        drain(1'b0, 100);
        repeat (20) @(posedge clk_2);
        #1;
        check("a_idle_partial_busy", {31'd0, busy_a}, 32'd0);
        check("a_partial_sum_held", {22'd0, ram_data_a}, 32'h30);
        q_a.push_back(8'h30); q_a.push_back(8'h40);
        exp_a.push_back('{addr: 11'd3, data: 10'd160});
        drain(1'b0, 100);

        // reset during CAPTURE of byte 3
        q_a.push_back(8'h05); q_a.push_back(8'h06); q_a.push_back(8'h07);
        k = 0;
        for (int i = 0; i < 100 && k < 3; i++) begin
            @(negedge clk_2);
            if (rd_a) k++;
        end
        check("a_third_rd_seen", k, 32'd3);
        @(posedge clk_2);
        #100;
        reset_a = 1'b1;
        #1;
        check("a_midpkt_reset_outputs", {26'd0, rd_a, ram_wr_a, busy_a, addr_full_a, 2'b00}, 32'd0);
        check("a_midpkt_reset_addr", {21'd0, ram_addr_a}, 32'd0);
        check("a_midpkt_reset_data", {22'd0, ram_data_a}, 32'd0);
        @(posedge clk_2); #1;
        reset_a = 1'b0;
        pkt_a(8'h01, 8'h01, 8'h01, 8'h01, 11'd0, 10'd4);
        drain(1'b0, 200);

        // ADDR_W=2: five packets of 1,1,1,1
        for (int p = 0; p < 5; p++) begin
            for (int j = 0; j < 4; j++) q_b.push_back(8'h01);
`ifdef RAM_ADDR_SAT_EN
            if (p < 4) exp_b.push_back('{addr: 11'(p), data: 10'd4});
`else
            exp_b.push_back('{addr: 11'(p % 4), data: 10'd4});
`endif
        end
        @(posedge clk_2); #1;
        reset_b = 1'b0;
        drain(1'b1, 400);
        check("b_rd_pulses", rd_cnt_b, 32'd20);
        check("b_busy_end", {31'd0, busy_b}, 32'd0);
`ifdef RAM_ADDR_SAT_EN
        check("b_addr_full", {31'd0, addr_full_b}, 32'd1);
        check("b_addr_hold", {30'd0, ram_addr_b}, 32'd3);
`else
        check("b_addr_full", {31'd0, addr_full_b}, 32'd0);
        check("b_addr_wrap", {30'd0, ram_addr_b}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
